// File: rtl/uart_sys_ctrl.sv
// rtl/uart_sys_ctrl.sv - UART command sequencer driving the register file, the ALU and the TX byte path
module uart_sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ALU_W      = 16,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_DATA_VLD,
    input  logic [ALU_W-1:0]      ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    input  logic                  TX_BUSY,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic                  CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CMD_ERR
);

    localparam logic [DATA_WIDTH-1:0] CMD_RF_WR   = DATA_WIDTH'('hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RF_RD   = DATA_WIDTH'('hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'('hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'('hDD);
    localparam logic [3:0]            RD_LAST     = 4'(RD_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OPA      = 4'd5,
        OPB      = 4'd6,
        FUN      = 4'd7,
        ALU_WAIT = 4'd8,
        TX0      = 4'd9,
        TX1      = 4'd10
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            rd_cnt;
    logic [DATA_WIDTH-1:0] tx_msb;
    logic                  tx_two;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            addr_q      <= '0;
            rd_cnt      <= '0;
            tx_msb      <= '0;
            tx_two      <= 1'b0;
            RF_ADDR     <= '0;
            RF_WR_DATA  <= '0;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            CMD_ERR     <= 1'b0;
        end else begin
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            ALU_EN   <= 1'b0;
            CMD_ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_RF_WR:   state <= WR_ADDR;
                            CMD_RF_RD:   state <= RD_ADDR;
                            CMD_ALU_OP:  state <= OPA;
                            CMD_ALU_NOP: begin
                                state       <= FUN;
                                CLK_GATE_EN <= 1'b1;
                            end
                            default:     CMD_ERR <= 1'b1;
                        endcase
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state  <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= addr_q;
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RD_EN <= 1'b1;
                        RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        rd_cnt   <= '0;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // A byte arriving while busy is dropped; a coincident read result still wins.
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                    if (RF_RD_DATA_VLD) begin
                        TX_P_DATA <= RF_RD_DATA;
                        TX_D_VLD  <= 1'b1;
                        tx_two    <= 1'b0;
                        state     <= TX0;
                    end else if (rd_cnt == RD_LAST) begin
                        CMD_ERR <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 4'd1;
                    end
                end
                OPA: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= '0;
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= OPB;
                    end
                end
                OPB: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN    <= 1'b1;
                        RF_ADDR     <= ADDR_WIDTH'(1);
                        RF_WR_DATA  <= RX_P_DATA;
                        CLK_GATE_EN <= 1'b1;
                        state       <= FUN;
                    end
                end
                FUN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN <= RX_P_DATA[3:0];
                        ALU_EN  <= 1'b1;
                        state   <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                    if (ALU_OUT_VLD) begin
                        TX_P_DATA   <= ALU_OUT[DATA_WIDTH-1:0];
                        tx_msb      <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                        tx_two      <= 1'b1;
                        TX_D_VLD    <= 1'b1;
                        CLK_GATE_EN <= 1'b0;
                        state       <= TX0;
                    end
                end
                TX0: begin
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                    if (!TX_BUSY) begin
                        TX_D_VLD <= 1'b0;
                        state    <= tx_two ? TX1 : IDLE;
                    end
                end
                TX1: begin
                    // Entered with TX_D_VLD low, which gives the mandatory gap before the MSB.
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                    if (!TX_D_VLD) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= tx_msb;
                    end else if (!TX_BUSY) begin
                        TX_D_VLD <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    CLK_GATE_EN <= 1'b0;
                    TX_D_VLD    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// tb/tb_uart_sys_ctrl.sv - directed self-checking bench for uart_sys_ctrl
module tb_uart_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RF_RD_DATA;
    logic        RF_RD_DATA_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        TX_BUSY;
    logic [3:0]  RF_ADDR;
    logic [7:0]  RF_WR_DATA;
    logic        RF_WR_EN;
    logic        RF_RD_EN;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        CMD_ERR;

    logic [29:0] outs;
    assign outs = {RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, ALU_FUN, ALU_EN,
                   CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR};

    int n_checks = 0;
    int n_fail   = 0;

    uart_sys_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_BUSY(TX_BUSY),
        .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA), .RF_WR_EN(RF_WR_EN),
        .RF_RD_EN(RF_RD_EN), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    // Called at a negedge; returns at the next negedge with the sampled byte's effects visible.
    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic collect_tx(input int cycles, output int n, output logic [7:0] b0,
                              output logic [7:0] b1, output bit gap_ok, output int errs);
        bit gapped;
        n = 0; b0 = 8'h00; b1 = 8'h00; gap_ok = 1'b1; gapped = 1'b0; errs = 0;
        for (int i = 0; i < cycles; i++) begin
            if (CMD_ERR) errs++;
            if (TX_D_VLD && !TX_BUSY) begin
                if (n == 0) b0 = TX_P_DATA;
                else if (n == 1) b1 = TX_P_DATA;
                if (n > 0 && !gapped) gap_ok = 1'b0;
                n++;
                gapped = 1'b0;
            end else if (!TX_D_VLD) begin
                gapped = 1'b1;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (outs !== 30'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", outs, 30'h0); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_rf_write();
        int n; logic [7:0] b0, b1; bit g; int e;
        send_byte(8'hAA);
        send_byte(8'h05);
        n_checks++;
        if (RF_WR_EN !== 1'b0) begin n_fail++; $display("FAIL wr_early_strobe: got %b expected 0", RF_WR_EN); end
        send_byte(8'h3C);
        n_checks++;
        if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h5, 8'h3C}) begin
            n_fail++; $display("FAIL wr_strobe: got %b/%h/%h expected 1/5/3c", RF_WR_EN, RF_ADDR, RF_WR_DATA);
        end
        @(negedge CLK);
        n_checks++;
        if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b0, 4'h5, 8'h3C}) begin
            n_fail++; $display("FAIL wr_hold: got %b/%h/%h expected 0/5/3c", RF_WR_EN, RF_ADDR, RF_WR_DATA);
        end
        collect_tx(5, n, b0, b1, g, e);
        n_checks++;
        if (n !== 0) begin n_fail++; $display("FAIL wr_no_tx: got %0d bytes expected 0", n); end
    endtask

    task automatic test_rf_read_busy();
        int held; int n; logic [7:0] b0, b1; bit g; int e;
        send_byte(8'hBB);
        send_byte(8'h02);
        n_checks++;
        if ({RF_RD_EN, RF_WR_EN, RF_ADDR} !== {1'b1, 1'b0, 4'h2}) begin
            n_fail++; $display("FAIL rd_strobe: got %b/%b/%h expected 1/0/2", RF_RD_EN, RF_WR_EN, RF_ADDR);
        end
        repeat (2) @(negedge CLK);
        RF_RD_DATA = 8'h7E; RF_RD_DATA_VLD = 1'b1; TX_BUSY = 1'b1;
        @(negedge CLK);
        RF_RD_DATA_VLD = 1'b0;
        n_checks++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h7E}) begin
            n_fail++; $display("FAIL rd_tx_present: got %b/%h expected 1/7e", TX_D_VLD, TX_P_DATA);
        end
        held = 0;
        repeat (9) begin
            @(negedge CLK);
            if (TX_D_VLD === 1'b1 && TX_P_DATA === 8'h7E) held++;
        end
        n_checks++;
        if (held !== 9) begin n_fail++; $display("FAIL rd_tx_held: got %0d cycles expected 9", held); end
        TX_BUSY = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (TX_D_VLD !== 1'b0) begin n_fail++; $display("FAIL rd_tx_release: got %b expected 0", TX_D_VLD); end
        collect_tx(5, n, b0, b1, g, e);
        n_checks++;
        if (n !== 0) begin n_fail++; $display("FAIL rd_no_repeat: got %0d bytes expected 0", n); end
    endtask

    task automatic test_alu_op();
        int n; logic [7:0] b0, b1; bit g; int e;
        send_byte(8'hCC);
        send_byte(8'h10);
        n_checks++;
        if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h0, 8'h10}) begin
            n_fail++; $display("FAIL opa_write: got %b/%h/%h expected 1/0/10", RF_WR_EN, RF_ADDR, RF_WR_DATA);
        end
        send_byte(8'h20);
        n_checks++;
        if ({RF_WR_EN, RF_ADDR, RF_WR_DATA, CLK_GATE_EN} !== {1'b1, 4'h1, 8'h20, 1'b1}) begin
            n_fail++; $display("FAIL opb_write: got %b/%h/%h/%b expected 1/1/20/1", RF_WR_EN, RF_ADDR, RF_WR_DATA, CLK_GATE_EN);
        end
        send_byte(8'h01);
        n_checks++;
        if ({ALU_EN, ALU_FUN, CLK_GATE_EN, RF_WR_EN} !== {1'b1, 4'h1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL alu_start: got %b/%h/%b/%b expected 1/1/1/0", ALU_EN, ALU_FUN, CLK_GATE_EN, RF_WR_EN);
        end
        ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        n_checks++;
        if ({ALU_EN, CLK_GATE_EN} !== 2'b00) begin
            n_fail++; $display("FAIL alu_gate_off: got %b/%b expected 0/0", ALU_EN, CLK_GATE_EN);
        end
        collect_tx(10, n, b0, b1, g, e);
        n_checks++;
        if ({n[3:0], b0, b1, g} !== {4'd2, 8'h34, 8'h12, 1'b1}) begin
            n_fail++; $display("FAIL alu_tx: got n=%0d %h %h gap=%b expected n=2 34 12 gap=1", n, b0, b1, g);
        end
    endtask

    task automatic test_unknown_then_nop();
        int n; logic [7:0] b0, b1; bit g; int e;
        send_byte(8'h55);
        n_checks++;
        if (CMD_ERR !== 1'b1) begin n_fail++; $display("FAIL unknown_err: got %b expected 1", CMD_ERR); end
        @(negedge CLK);
        n_checks++;
        if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL unknown_err_pulse: got %b expected 0", CMD_ERR); end
        send_byte(8'hDD);
        n_checks++;
        if ({CLK_GATE_EN, CMD_ERR} !== 2'b10) begin
            n_fail++; $display("FAIL nop_fun_gate: got %b/%b expected 1/0", CLK_GATE_EN, CMD_ERR);
        end
        send_byte(8'h03);
        n_checks++;
        if ({ALU_EN, ALU_FUN} !== {1'b1, 4'h3}) begin
            n_fail++; $display("FAIL nop_alu_start: got %b/%h expected 1/3", ALU_EN, ALU_FUN);
        end
        ALU_OUT = 16'hBEEF; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        collect_tx(10, n, b0, b1, g, e);
        n_checks++;
        if ({n[3:0], b0, b1, g, e[3:0]} !== {4'd2, 8'hEF, 8'hBE, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL nop_tx: got n=%0d %h %h gap=%b err=%0d expected n=2 ef be gap=1 err=0", n, b0, b1, g, e);
        end
    endtask

    task automatic test_rd_timeout();
        int n; bit tx_seen;
        send_byte(8'hBB);
        send_byte(8'h01);
        n_checks++;
        if (RF_RD_EN !== 1'b1) begin n_fail++; $display("FAIL to_rd_strobe: got %b expected 1", RF_RD_EN); end
        n = 0; tx_seen = 1'b0;
        while (n < 40) begin
            @(negedge CLK);
            n++;
            if (TX_D_VLD) tx_seen = 1'b1;
            if (CMD_ERR) break;
        end
        n_checks++;
        if (n !== 15) begin n_fail++; $display("FAIL to_latency: got %0d cycles expected 15", n); end
        n_checks++;
        if (tx_seen !== 1'b0) begin n_fail++; $display("FAIL to_no_tx: got %b expected 0", tx_seen); end
        @(negedge CLK);
        n_checks++;
        if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse: got %b expected 0", CMD_ERR); end
    endtask

    task automatic test_overrun_tx1();
        send_byte(8'hDD);
        send_byte(8'h07);
        ALU_OUT = 16'h00A5; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        n_checks++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'hA5}) begin
            n_fail++; $display("FAIL ovr_byte0: got %b/%h expected 1/a5", TX_D_VLD, TX_P_DATA);
        end
        @(negedge CLK);
        n_checks++;
        if (TX_D_VLD !== 1'b0) begin n_fail++; $display("FAIL ovr_gap: got %b expected 0", TX_D_VLD); end
        send_byte(8'hAA);
        n_checks++;
        if ({CMD_ERR, TX_D_VLD, TX_P_DATA} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL ovr_err_byte1: got %b/%b/%h expected 1/1/00", CMD_ERR, TX_D_VLD, TX_P_DATA);
        end
        @(negedge CLK);
        n_checks++;
        if ({CMD_ERR, TX_D_VLD} !== 2'b00) begin
            n_fail++; $display("FAIL ovr_done: got %b/%b expected 0/0", CMD_ERR, TX_D_VLD);
        end
        send_byte(8'hAA);
        send_byte(8'h0F);
        send_byte(8'h99);
        n_checks++;
        if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'hF, 8'h99}) begin
            n_fail++; $display("FAIL ovr_next_cmd: got %b/%h/%h expected 1/f/99", RF_WR_EN, RF_ADDR, RF_WR_DATA);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_midflight();
        int n; logic [7:0] b0, b1; bit g; int e;
        send_byte(8'hDD);
        send_byte(8'h02);
        n_checks++;
        if (CLK_GATE_EN !== 1'b1) begin n_fail++; $display("FAIL rst_alu_wait_gate: got %b expected 1", CLK_GATE_EN); end
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (outs !== 30'h0) begin n_fail++; $display("FAIL rst_alu_wait_outs: got %h expected %h", outs, 30'h0); end
        RST = 1'b0;
        ALU_OUT = 16'hFFFF; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        collect_tx(6, n, b0, b1, g, e);
        n_checks++;
        if (n !== 0) begin n_fail++; $display("FAIL rst_alu_ignored: got %0d bytes expected 0", n); end
        send_byte(8'hBB);
        send_byte(8'h03);
        RF_RD_DATA = 8'h5A; RF_RD_DATA_VLD = 1'b1; TX_BUSY = 1'b1;
        @(negedge CLK);
        RF_RD_DATA_VLD = 1'b0;
        n_checks++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h5A}) begin
            n_fail++; $display("FAIL rst_tx0_present: got %b/%h expected 1/5a", TX_D_VLD, TX_P_DATA);
        end
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (outs !== 30'h0) begin n_fail++; $display("FAIL rst_tx0_outs: got %h expected %h", outs, 30'h0); end
        RST = 1'b0;
        TX_BUSY = 1'b0;
        collect_tx(6, n, b0, b1, g, e);
        n_checks++;
        if (n !== 0) begin n_fail++; $display("FAIL rst_tx0_no_tx: got %0d bytes expected 0", n); end
    endtask

    initial begin
        RST = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; RF_RD_DATA = 8'h00; RF_RD_DATA_VLD = 1'b0;
        ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0; TX_BUSY = 1'b0;
        test_reset();
        test_rf_write();
        test_rf_read_busy();
        test_alu_op();
        test_unknown_then_nop();
        test_rd_timeout();
        test_overrun_tx1();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
